vram_user_arbiter: RTL

Controller for the 24 KiB frame-buffer VRAM user port (read latency 1 cycle). It lets two requesters share that single port: host byte read/write accesses and a built-in linear fill engine that writes one constant byte per cycle. When both request, the two alternate cycle by cycle. The block also bounds-checks every access against the VRAM depth. It sits between the host bus bridge and the VRAM user port, in the user_clk domain.

---
 rtl/vram_pkg.sv | 19 +
 rtl/vram_fill_seq.sv | 71 +++++++
 rtl/vram_user_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM geometry plus the state and turn encodings used by the
// frame-buffer user-port controllers.
package vram_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;
  localparam int VRAM_DEPTH  = 24576;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  typedef enum logic {
    TURN_HOST,
    TURN_FILL
  } turn_t;

endpackage

// File: rtl/vram_fill_seq.sv
// Linear fill sequencer: clips the requested run at DEPTH, then walks
// cur/rem one byte per granted step and flags completion.
module vram_fill_seq
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] start_len,
  input  logic [DATA_W-1:0] start_value,
  input  logic              step,
  output logic [ADDR_W-1:0] cur,
  output logic [DATA_W-1:0] value,
  output logic              run,
  output logic              last,
  output logic              done,
  output logic              clipped
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] eff_len;

  // Length that fits between addr and the end of VRAM; zero when addr is already past it.
  function automatic logic [ADDR_W-1:0] clip_len(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] len);
    logic [ADDR_W:0] room;
    clip_len = '0;
    room     = '0;
    if ({1'b0, addr} < DEPTH_X) begin
      room     = DEPTH_X - {1'b0, addr};
      clip_len = ({1'b0, len} < room) ? len : room[ADDR_W-1:0];
    end
  endfunction

  assign eff_len = clip_len(start_addr, start_len);
  assign run     = start && (eff_len != '0);
  assign last    = (rem == ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      rem     <= '0;
      done    <= 1'b0;
      clipped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cur     <= start_addr;
        rem     <= eff_len;
        clipped <= (eff_len != start_len);
        done    <= (eff_len == '0);
      end else if (step) begin
        cur  <= cur + 1'b1;
        rem  <= rem - 1'b1;
        done <= last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) value <= start_value;
  end

endmodule

// File: rtl/vram_user_arbiter.sv
// VRAM user-port controller: host byte accesses and the fill engine share
// one registered port, alternating cycle by cycle under contention.
module vram_user_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic              user_clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fill_clipped,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;
  turn_t  turn_q;

  logic              host_grant;
  logic              fill_grant;
  logic              fill_accept;
  logic              host_in_range;
  logic [ADDR_W-1:0] seq_cur;
  logic [DATA_W-1:0] seq_value;
  logic              seq_run;
  logic              seq_last;

  logic rd_vld_p1, oor_p1;
  logic oor_p2;

  assign host_ready    = (state_q == ST_IDLE) || (turn_q == TURN_HOST) || !host_req;
  assign host_grant    = host_req && host_ready;
  assign fill_grant    = (state_q == ST_FILL) && !host_grant;
  assign fill_accept   = fill_start && (state_q == ST_IDLE);
  assign host_in_range = ({1'b0, host_addr} < DEPTH_X);
  assign fill_busy     = (state_q == ST_FILL);

  vram_fill_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fill_seq (
    .clk         (user_clk),
    .rst         (rst),
    .start       (fill_accept),
    .start_addr  (fill_addr),
    .start_len   (fill_len),
    .start_value (fill_value),
    .step        (fill_grant),
    .cur         (seq_cur),
    .value       (seq_value),
    .run         (seq_run),
    .last        (seq_last),
    .done        (fill_done),
    .clipped     (fill_clipped)
  );

  always_ff @(posedge user_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (seq_run) state_d = ST_FILL;
      ST_FILL: if (fill_grant && seq_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every fill begins with the host holding priority for the first contended slot.
  always_ff @(posedge user_clk) begin
    if (rst)                                    turn_q <= TURN_HOST;
    else if (fill_accept)                       turn_q <= TURN_HOST;
    else if ((state_q == ST_FILL) && host_req)  turn_q <= (turn_q == TURN_HOST) ? TURN_FILL : TURN_HOST;
  end

  // Stage p1: registered VRAM port; out-of-range host accesses never reach it.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      rd_vld_p1  <= 1'b0;
      oor_p1     <= 1'b0;
    end else begin
      vram_we   <= 1'b0;
      rd_vld_p1 <= host_grant && !host_we;
      oor_p1    <= !host_in_range;
      if (host_grant) begin
        if (host_in_range) begin
          vram_addr <= host_addr;
          vram_we   <= host_we;
          if (host_we) vram_wdata <= host_wdata;
        end
      end else if (fill_grant) begin
        vram_addr  <= seq_cur;
        vram_we    <= 1'b1;
        vram_wdata <= seq_value;
      end
    end
  end

  // Stage p2: VRAM read data arrives; the host samples it at the end of this cycle.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      oor_p2      <= 1'b0;
    end else begin
      host_rvalid <= rd_vld_p1;
      oor_p2      <= oor_p1;
    end
  end

  assign host_rdata = (host_rvalid && !oor_p2) ? vram_rdata : '0;

endmodule
